// File: rtl/load_unit.sv
// -----------------------------------------------------------------------------
// load_unit
//   Issues one load from the load-queue head. A load whose data was already
//   forwarded from a store is broadcast on the CDB the cycle after acceptance.
//   Any other load reads data memory, then broadcasts the formatted result.
//   On a flush, an outstanding memory read is allowed to finish in DRAIN and its
//   data is discarded. That response can never be taken for a later load.
//
// Ports
//   clk, rst_n                clock and asynchronous active-low reset
//   flush                     pipeline flush
//   load_req / load_ack       load-queue handshake (ack is combinational)
//   req_*                     load attributes sampled on acceptance
//   dmem_addr / dmem_rmask    memory read request, held through WAIT
//   dmem_rdata / dmem_resp    memory read response
//   cdb_*                     registered CDB broadcast (cdb_regf_we is a pulse)
// -----------------------------------------------------------------------------
module load_unit #(
  parameter int PD_W  = 6,
  parameter int ROB_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load_req,
  output logic             load_ack,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_addr2,
  input  logic [3:0]       req_rmask,
  input  logic [2:0]       req_funct3,
  input  logic [4:0]       req_rd,
  input  logic [PD_W-1:0]  req_pd,
  input  logic [ROB_W-1:0] req_rob,
  input  logic [31:0]      req_pc,
  input  logic             req_data_available,
  input  logic [31:0]      req_load_data,
  output logic [31:0]      dmem_addr,
  output logic [3:0]       dmem_rmask,
  input  logic [31:0]      dmem_rdata,
  input  logic             dmem_resp,
  output logic             cdb_regf_we,
  output logic [PD_W-1:0]  cdb_pd,
  output logic [4:0]       cdb_rd,
  output logic [ROB_W-1:0] cdb_rob,
  output logic [31:0]      cdb_pc,
  output logic [31:0]      cdb_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN} state_e;

  state_e           state_q;
  logic [31:0]      addr_q;
  logic [1:0]       off_q;
  logic [3:0]       rmask_q;
  logic [2:0]       funct3_q;
  logic [4:0]       rd_q;
  logic [PD_W-1:0]  pd_q;
  logic [ROB_W-1:0] rob_q;
  logic [31:0]      pc_q;

  logic             cdb_we_q;
  logic [PD_W-1:0]  cdb_pd_q;
  logic [4:0]       cdb_rd_q;
  logic [ROB_W-1:0] cdb_rob_q;
  logic [31:0]      cdb_pc_q;
  logic [31:0]      cdb_data_q;

  logic [31:0]      mem_shifted_d;
  logic [31:0]      mem_data_d;
  logic [31:0]      fwd_data_d;

  // Only the byte offset of the byte address is meaningful here.
  logic unused_addr2;
  assign unused_addr2 = ^req_addr2[31:2];

  // Per-funct3 result formatting shared by the memory and forwarding paths.
  function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b100:  return {24'd0, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b101:  return {16'd0, d[15:0]};
      3'b010:  return d;
      default: return 32'd0;
    endcase
  endfunction

  assign mem_shifted_d = dmem_rdata >> {off_q, 3'b000};
  assign mem_data_d    = fmt_load(mem_shifted_d, funct3_q);
  assign fwd_data_d    = fmt_load(req_load_data, req_funct3);

  // Gated by rst_n so that no request can be acknowledged while reset is held.
  assign load_ack = rst_n && load_req && (state_q == ST_IDLE) && !flush;

  assign dmem_addr  = (state_q == ST_WAIT) ? addr_q  : 32'd0;
  assign dmem_rmask = (state_q == ST_WAIT) ? rmask_q : 4'd0;

  assign cdb_regf_we = cdb_we_q;
  assign cdb_pd      = cdb_pd_q;
  assign cdb_rd      = cdb_rd_q;
  assign cdb_rob     = cdb_rob_q;
  assign cdb_pc      = cdb_pc_q;
  assign cdb_data    = cdb_data_q;

  // NOTE: every register, including the latched request fields, is reset so
  // that no stale payload is visible after reset. Non-blocking assignments keep
  // all updates in this block based on values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      off_q      <= '0;
      rmask_q    <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      pd_q       <= '0;
      rob_q      <= '0;
      pc_q       <= '0;
      cdb_we_q   <= 1'b0;
      cdb_pd_q   <= '0;
      cdb_rd_q   <= '0;
      cdb_rob_q  <= '0;
      cdb_pc_q   <= '0;
      cdb_data_q <= '0;
    end else begin
      // The broadcast is a single-cycle pulse unless re-armed below.
      cdb_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_ack) begin
            addr_q   <= req_addr;
            off_q    <= req_addr2[1:0];
            rmask_q  <= req_rmask;
            funct3_q <= req_funct3;
            rd_q     <= req_rd;
            pd_q     <= req_pd;
            rob_q    <= req_rob;
            pc_q     <= req_pc;
            if (req_data_available) begin
              cdb_we_q   <= 1'b1;
              cdb_pd_q   <= req_pd;
              cdb_rd_q   <= req_rd;
              cdb_rob_q  <= req_rob;
              cdb_pc_q   <= req_pc;
              cdb_data_q <= fwd_data_d;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dmem_resp) begin
            state_q <= ST_IDLE;
            // A response coinciding with a flush belongs to a squashed load.
            if (!flush) begin
              cdb_we_q   <= 1'b1;
              cdb_pd_q   <= pd_q;
              cdb_rd_q   <= rd_q;
              cdb_rob_q  <= rob_q;
              cdb_pc_q   <= pc_q;
              cdb_data_q <= mem_data_d;
            end
          end else if (flush) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (dmem_resp) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;

  localparam int PD_W  = 6;
  localparam int ROB_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             load_req;
  logic             load_ack;
  logic [31:0]      req_addr;
  logic [31:0]      req_addr2;
  logic [3:0]       req_rmask;
  logic [2:0]       req_funct3;
  logic [4:0]       req_rd;
  logic [PD_W-1:0]  req_pd;
  logic [ROB_W-1:0] req_rob;
  logic [31:0]      req_pc;
  logic             req_data_available;
  logic [31:0]      req_load_data;
  logic [31:0]      dmem_addr;
  logic [3:0]       dmem_rmask;
  logic [31:0]      dmem_rdata;
  logic             dmem_resp;
  logic             cdb_regf_we;
  logic [PD_W-1:0]  cdb_pd;
  logic [4:0]       cdb_rd;
  logic [ROB_W-1:0] cdb_rob;
  logic [31:0]      cdb_pc;
  logic [31:0]      cdb_data;

  load_unit #(.PD_W(PD_W), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .load_req(load_req), .load_ack(load_ack),
    .req_addr(req_addr), .req_addr2(req_addr2), .req_rmask(req_rmask),
    .req_funct3(req_funct3), .req_rd(req_rd), .req_pd(req_pd), .req_rob(req_rob),
    .req_pc(req_pc), .req_data_available(req_data_available),
    .req_load_data(req_load_data),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .cdb_regf_we(cdb_regf_we), .cdb_pd(cdb_pd), .cdb_rd(cdb_rd),
    .cdb_rob(cdb_rob), .cdb_pc(cdb_pc), .cdb_data(cdb_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a load is either done at once (forwarded) or becomes the
  // single outstanding memory transaction; a flushed memory transaction turns
  // into an orphan response that must be swallowed before new work starts.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0]      addr;
    int               off;
    logic [3:0]       rmask;
    logic [2:0]       f3;
    logic [4:0]       rd;
    logic [PD_W-1:0]  pd;
    logic [ROB_W-1:0] rob;
    logic [31:0]      pc;
  } txn_t;

  txn_t             pend_q[$];
  bit               orphan;
  bit               exp_ack;
  bit               exp_we;
  logic [PD_W-1:0]  exp_pd;
  logic [4:0]       exp_rd;
  logic [ROB_W-1:0] exp_rob;
  logic [31:0]      exp_pc;
  logic [31:0]      exp_data;

  // Values the DUT showed during the most recent step's input cycle.
  logic             ack_seen;
  logic [3:0]       rmask_seen;
  logic [31:0]      addr_seen;

  function automatic logic [31:0] fmt_ref(input logic [31:0] v, input logic [2:0] f3);
    longint b = longint'(v) & 64'hFF;
    longint h = longint'(v) & 64'hFFFF;
    longint r;
    case (f3)
      3'd0:    r = (b >= 128)   ? b - 256   : b;
      3'd4:    r = b;
      3'd1:    r = (h >= 32768) ? h - 65536 : h;
      3'd5:    r = h;
      3'd2:    r = longint'(v);
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic model_reset();
    pend_q.delete();
    orphan   = 0;
    exp_we   = 0;
    exp_pd   = '0;
    exp_rd   = '0;
    exp_rob  = '0;
    exp_pc   = '0;
    exp_data = '0;
  endtask

  task automatic model_update();
    txn_t t;
    exp_we = 0;
    if (exp_ack) begin
      t.addr = req_addr; t.off = int'(req_addr2 % 4); t.rmask = req_rmask;
      t.f3 = req_funct3; t.rd = req_rd; t.pd = req_pd; t.rob = req_rob; t.pc = req_pc;
      if (req_data_available) begin
        exp_we = 1; exp_pd = t.pd; exp_rd = t.rd; exp_rob = t.rob; exp_pc = t.pc;
        exp_data = fmt_ref(req_load_data, t.f3);
      end else begin
        pend_q.push_back(t);
      end
    end else if (pend_q.size() != 0) begin
      if (dmem_resp) begin
        t = pend_q.pop_front();
        if (!flush) begin
          exp_we = 1; exp_pd = t.pd; exp_rd = t.rd; exp_rob = t.rob; exp_pc = t.pc;
          exp_data = fmt_ref(dmem_rdata >> (8 * t.off), t.f3);
        end
      end else if (flush) begin
        void'(pend_q.pop_front());
        orphan = 1;
      end
    end else if (orphan && dmem_resp) begin
      orphan = 0;
    end
  endtask

  // One clock cycle: inputs were set at the falling edge by the caller.
  task automatic step();
    #1;
    exp_ack = rst_n && load_req && !flush && pend_q.size() == 0 && !orphan;
    check("load_ack", 32'(load_ack), 32'(exp_ack));
    if (pend_q.size() != 0) begin
      check("dmem_addr", dmem_addr, pend_q[0].addr);
      check("dmem_rmask", 32'(dmem_rmask), 32'(pend_q[0].rmask));
    end else begin
      check("dmem_addr_idle", dmem_addr, 32'd0);
      check("dmem_rmask_idle", 32'(dmem_rmask), 32'd0);
    end
    ack_seen = load_ack; rmask_seen = dmem_rmask; addr_seen = dmem_addr;
    model_update();
    @(posedge clk);
    @(negedge clk);
    check("cdb_regf_we", 32'(cdb_regf_we), 32'(exp_we));
    if (exp_we) begin
      check("cdb_pd", 32'(cdb_pd), 32'(exp_pd));
      check("cdb_rd", 32'(cdb_rd), 32'(exp_rd));
      check("cdb_rob", 32'(cdb_rob), 32'(exp_rob));
      check("cdb_pc", cdb_pc, exp_pc);
      check("cdb_data", cdb_data, exp_data);
    end
  endtask

  task automatic clear_inputs();
    flush = 0; load_req = 0; req_addr = '0; req_addr2 = '0; req_rmask = '0;
    req_funct3 = '0; req_rd = '0; req_pd = '0; req_rob = '0; req_pc = '0;
    req_data_available = 0; req_load_data = '0; dmem_rdata = '0; dmem_resp = 0;
  endtask

  task automatic set_load(input logic [31:0] a2, input logic [3:0] m, input logic [2:0] f3,
                          input bit avail, input logic [31:0] fdata, input int tag);
    load_req = 1; req_addr2 = a2; req_addr = a2 & 32'hFFFF_FFFC; req_rmask = m;
    req_funct3 = f3; req_data_available = avail; req_load_data = fdata;
    req_pd = PD_W'(tag); req_rob = ROB_W'(tag); req_rd = 5'(tag);
    req_pc = 32'h0000_4000 + 32'(tag * 4);
  endtask

  // Formatting vectors: forwarded (mem=0) or from memory at a byte offset.
  typedef struct {
    bit          mem;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{0, 3'd0, 2'd0, 32'h0000_00F0, 32'hFFFF_FFF0};
    vecs[1]  = '{0, 3'd4, 2'd0, 32'h1234_56F0, 32'h0000_00F0};
    vecs[2]  = '{0, 3'd1, 2'd0, 32'h0000_8001, 32'hFFFF_8001};
    vecs[3]  = '{0, 3'd5, 2'd0, 32'hFFFF_8001, 32'h0000_8001};
    vecs[4]  = '{0, 3'd2, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[5]  = '{0, 3'd3, 2'd0, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[6]  = '{0, 3'd7, 2'd0, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7]  = '{1, 3'd0, 2'd3, 32'h8012_3456, 32'hFFFF_FF80};
    vecs[8]  = '{1, 3'd4, 2'd1, 32'h0000_7F00, 32'h0000_007F};
    vecs[9]  = '{1, 3'd1, 2'd2, 32'h8001_ABCD, 32'hFFFF_8001};
    vecs[10] = '{1, 3'd5, 2'd0, 32'h1234_F00D, 32'h0000_F00D};
    vecs[11] = '{1, 3'd2, 2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[12] = '{1, 3'd6, 2'd1, 32'h1234_5678, 32'h0000_0000};

    clear_inputs();
    rst_n = 0;
    model_reset();
    load_req = 1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ack", 32'(load_ack), 32'd0);
    check("reset_cdb_we", 32'(cdb_regf_we), 32'd0);
    check("reset_cdb_data", cdb_data, 32'd0);
    check("reset_cdb_pd", 32'(cdb_pd), 32'd0);
    check("reset_dmem_rmask", 32'(dmem_rmask), 32'd0);
    check("reset_dmem_addr", dmem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1;
    clear_inputs();

    // Forwarded lb: next-cycle broadcast, no memory request.
    set_load(32'h0, 4'b0001, 3'b000, 1, 32'h0000_00F0, 7);
    step();
    check("fwd_lb_ack", 32'(ack_seen), 32'd1);
    check("fwd_lb_rmask", 32'(rmask_seen), 32'd0);
    check("fwd_lb_pd", 32'(cdb_pd), 32'd7);
    check("fwd_lb_data", cdb_data, 32'hFFFF_FFF0);
    check("fwd_lb_no_mem", 32'(dmem_rmask), 32'd0);
    clear_inputs();
    step();

    // Formatting table.
    for (int i = 0; i < 13; i++) begin
      set_load(32'h3000 | 32'(vecs[i].off), 4'b1111, vecs[i].f3, !vecs[i].mem, vecs[i].data, i + 1);
      step();
      if (vecs[i].mem) begin
        clear_inputs();
        dmem_resp = 1; dmem_rdata = vecs[i].data;
        step();
      end
      check($sformatf("vec%0d_we", i), 32'(cdb_regf_we), 32'd1);
      check($sformatf("vec%0d_data", i), cdb_data, vecs[i].exp);
      clear_inputs();
    end
    step();

    // Memory lhu with a response on the third WAIT cycle.
    set_load(32'h1002, 4'b1100, 3'b101, 0, 32'h0, 9);
    step();
    clear_inputs();
    step();
    check("lhu_wait_addr", addr_seen, 32'h1000);
    check("lhu_wait_rmask", 32'(rmask_seen), 32'(4'b1100));
    step();
    check("lhu_no_early_we", 32'(cdb_regf_we), 32'd0);
    dmem_resp = 1; dmem_rdata = 32'h8001_ABCD;
    step();
    check("lhu_we", 32'(cdb_regf_we), 32'd1);
    check("lhu_data", cdb_data, 32'h0000_8001);
    clear_inputs();
    step();
    check("lhu_pulse_end", 32'(cdb_regf_we), 32'd0);

    // Three back-to-back forwarded loads.
    for (int i = 0; i < 3; i++) begin
      set_load(32'h0, 4'b1111, 3'b010, 1, 32'h100 + 32'(i), 10 + i);
      step();
      check($sformatf("b2b%0d_ack", i), 32'(ack_seen), 32'd1);
      check($sformatf("b2b%0d_we", i), 32'(cdb_regf_we), 32'd1);
      check($sformatf("b2b%0d_pd", i), 32'(cdb_pd), 32'(10 + i));
      check($sformatf("b2b%0d_rob", i), 32'(cdb_rob), 32'(10 + i));
    end
    clear_inputs();
    step();
    check("b2b_end", 32'(cdb_regf_we), 32'd0);

    // Flush two cycles into WAIT with a new request held high.
    set_load(32'h1000, 4'b1111, 3'b010, 0, 32'h0, 20);
    step();
    set_load(32'h5000, 4'b1111, 3'b010, 1, 32'h55, 21);
    step();
    step();
    flush = 1;
    step();
    check("flush_wait_ack", 32'(ack_seen), 32'd0);
    flush = 0;
    step();
    check("drain_ack", 32'(ack_seen), 32'd0);
    check("drain_rmask", 32'(rmask_seen), 32'd0);
    dmem_resp = 1; dmem_rdata = 32'hBAD0_BAD0;
    step();
    check("drain_resp_no_we", 32'(cdb_regf_we), 32'd0);
    dmem_resp = 0;
    step();
    check("post_drain_ack", 32'(ack_seen), 32'd1);
    check("post_drain_data", cdb_data, 32'h55);

    // Flush coincident with the response.
    set_load(32'h1004, 4'b1111, 3'b010, 0, 32'h0, 22);
    step();
    clear_inputs();
    flush = 1; dmem_resp = 1; dmem_rdata = 32'h1234_5678;
    step();
    check("flush_resp_no_we", 32'(cdb_regf_we), 32'd0);
    clear_inputs();
    set_load(32'h0, 4'b1111, 3'b010, 1, 32'h77, 23);
    step();
    check("flush_resp_idle_ack", 32'(ack_seen), 32'd1);
    clear_inputs();
    step();

    // Asynchronous reset mid-WAIT, then a normal lw.
    set_load(32'h1008, 4'b1111, 3'b010, 0, 32'h0, 24);
    step();
    step();
    rst_n = 0;
    #1;
    check("rst_wait_rmask", 32'(dmem_rmask), 32'd0);
    check("rst_wait_addr", dmem_addr, 32'd0);
    check("rst_wait_we", 32'(cdb_regf_we), 32'd0);
    check("rst_wait_ack", 32'(load_ack), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    clear_inputs();
    set_load(32'h2000, 4'b1111, 3'b010, 0, 32'h0, 25);
    step();
    clear_inputs();
    dmem_resp = 1; dmem_rdata = 32'h1122_3344;
    step();
    check("post_rst_lw_we", 32'(cdb_regf_we), 32'd1);
    check("post_rst_lw_data", cdb_data, 32'h1122_3344);
    clear_inputs();

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] r;
      r = $urandom;
      load_req = ($urandom_range(0, 99) < 60);
      flush    = ($urandom_range(0, 99) < 8);
      dmem_resp = ($urandom_range(0, 99) < 30);
      dmem_rdata = $urandom;
      req_data_available = ($urandom_range(0, 99) < 50);
      req_load_data = $urandom;
      req_addr = r & 32'hFFFF_FFFC;
      req_addr2 = r;
      req_rmask = 4'($urandom);
      req_funct3 = 3'($urandom);
      req_rd = 5'($urandom);
      req_pd = PD_W'($urandom);
      req_rob = ROB_W'($urandom);
      req_pc = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 SHALL have parameter PD_W, default 6, physical register index width.
REQ-002 SHALL have parameter ROB_W, default 5, ROB index width.
REQ-003 SHALL have ports as follows; one clock; reset is asynchronous and active-low:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  pipeline flush.
- load_req  input  1  load queue head ready to issue.
- load_ack  output  1  request accepted this cycle.
- req_addr  input  32  word-aligned address.
- req_addr2  input  32  byte address; bits [1:0] are the byte offset.
- req_rmask  input  4  byte read mask.
- req_funct3  input  3  load type: lb=000, lh=001, lw=010, lbu=100, lhu=101.
- req_rd  input  5  architectural destination.
- req_pd  input  PD_W  physical destination.
- req_rob  input  ROB_W  ROB entry.
- req_pc  input  32  load PC.
- req_data_available  input  1  store-forwarded data valid.
- req_load_data  input  32  forwarded store value.
- dmem_addr  output  32  memory read address.
- dmem_rmask  output  4  memory read mask; nonzero means read request.
- dmem_rdata  input  32  memory read data.
- dmem_resp  input  1  memory response valid.
- cdb_regf_we  output  1  CDB broadcast valid.
- cdb_pd  output  PD_W  broadcast physical register.
- cdb_rd  output  5  broadcast architectural register.
- cdb_rob  output  ROB_W  broadcast ROB entry.
- cdb_pc  output  32  broadcast PC.
- cdb_data  output  32  formatted load result.

Function
REQ-004 SHALL implement states IDLE, WAIT, DRAIN.
REQ-005 SHALL drive load_ack = load_req && state==IDLE && !flush, combinationally.
REQ-006 On accept, SHALL latch addr, addr2[1:0], rmask, funct3, rd, pd, rob, pc.
REQ-007 Accept with req_data_available=1: SHALL stay IDLE and assert cdb_regf_we the next cycle with formatted req_load_data; no memory access.
REQ-008 Accept with req_data_available=0: SHALL enter WAIT next cycle.
REQ-009 In WAIT, SHALL hold dmem_addr and dmem_rmask at the latched values every cycle until dmem_resp.
REQ-010 In every state other than WAIT, SHALL drive dmem_rmask=0 and dmem_addr=0.
REQ-011 dmem_resp in WAIT without flush: SHALL go to IDLE and assert cdb_regf_we the next cycle with formatted dmem_rdata.
REQ-012 CDB outputs SHALL be registered and cdb_regf_we SHALL be a one-cycle pulse.
REQ-013 Memory formatting SHALL use shifted = dmem_rdata >> (8*offset):
- lb: sign-extend shifted[7:0].
- lbu: zero-extend shifted[7:0].
- lh: sign-extend shifted[15:0].
- lhu: zero-extend shifted[15:0].
- lw: full word.
- any other funct3: 0.
REQ-014 Forwarded formatting SHALL apply the same per-funct3 rules to req_load_data with no shift.
REQ-015 Peak throughput SHALL be one forwarded load per cycle; a memory load SHALL block further accepts until it leaves WAIT.
REQ-016 Flush in IDLE: SHALL cancel any same-cycle accept; cdb_regf_we SHALL be 0 the next cycle.
REQ-017 Flush in WAIT without dmem_resp: SHALL enter DRAIN.
REQ-018 Flush in WAIT with dmem_resp in the same cycle: SHALL return to IDLE with no broadcast.
REQ-019 In DRAIN, SHALL ignore load_req, wait for dmem_resp, discard the data, then return to IDLE.
REQ-020 Flush in DRAIN SHALL have no additional effect.
REQ-021 dmem_resp in IDLE SHALL be ignored.
REQ-022 A flush cycle SHALL force cdb_regf_we=0 on the following cycle, including any broadcast pending from the flush cycle.

Reset
REQ-023 While rst_n=0, SHALL hold state=IDLE, cdb_regf_we=0, all cdb_* fields=0, all latched fields=0, dmem_rmask=0, dmem_addr=0.
REQ-024 Reset SHALL take effect asynchronously, including mid-WAIT and mid-DRAIN; the outstanding response is not tracked after reset.
REQ-025 load_ack SHALL be 0 during reset.

Verification
REQ-026 Forwarded lb: req_data_available=1, req_load_data=0x000000F0, funct3=000, pd=7 -> ack same cycle; next cycle cdb_regf_we=1, cdb_pd=7, cdb_data=0xFFFFFFF0; no dmem_rmask.
REQ-027 Memory lhu: addr2=0x1002, rmask=1100 -> WAIT with dmem_addr=0x1000, dmem_rmask=1100; resp after 3 cycles with rdata=0x8001ABCD -> next cycle cdb_data=0x00008001.
REQ-028 Back-to-back forwarded loads on 3 consecutive cycles -> 3 acks and 3 consecutive single-cycle CDB pulses with the matching pd/rob.
REQ-029 Flush two cycles into WAIT, new load_req held high -> DRAIN with load_ack=0; resp arrives -> no CDB pulse; next cycle IDLE and the new request is acked.
REQ-030 Flush coincident with dmem_resp in WAIT -> no CDB pulse; IDLE next cycle.
REQ-031 rst_n asserted low mid-WAIT -> immediate IDLE, dmem_rmask=0, cdb_regf_we=0; lw at addr2=0x2000 after release completes normally.
